// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - EX/MEM data-memory access controller with wait/timeout handling
// Two-state (IDLE/WAIT) controller issuing one data-memory request at a time toward MEM/WB.
module mem_access_ctrl #(
    parameter int S       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ex_valid,
    input  logic         ex_memread,
    input  logic         ex_memwrite,
    input  logic [S-1:0] ex_addr,
    input  logic [S-1:0] ex_wdata,
    input  logic         flush,
    output logic         mem_req,
    output logic         mem_we,
    output logic [S-1:0] mem_addr,
    output logic [S-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [S-1:0] mem_rdata,
    output logic         stall,
    output logic         wb_valid,
    output logic [S-1:0] wb_ReadData,
    output logic         misalign_err,
    output logic         timeout_err
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t       state_q;
    logic         mem_req_q;
    logic         mem_we_q;
    logic [S-1:0] mem_addr_q;
    logic [S-1:0] mem_wdata_q;
    logic         wb_valid_q;
    logic [S-1:0] wb_data_q;
    logic         misalign_q;
    logic         timeout_q;
    logic [7:0]   wait_cnt_q;
    logic         discard_q;

    logic ex_is_mem;
    logic ex_is_write;
    logic ex_aligned;
    logic wait_done;
    logic wb_suppress;

    // A simultaneous read+write request is treated as a load.
    assign ex_is_mem   = ex_memread | ex_memwrite;
    assign ex_is_write = ex_memwrite & ~ex_memread;
    assign ex_aligned  = (ex_addr[1:0] == 2'b00);
    assign wait_done   = mem_ack || (wait_cnt_q == WAIT_LAST);
    assign wb_suppress = discard_q | flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
            discard_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid && !flush) begin
                        if (!ex_is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                        end else if (!ex_aligned) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                            misalign_q <= 1'b1;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ex_is_write;
                            mem_addr_q  <= ex_addr;
                            mem_wdata_q <= ex_wdata;
                            wait_cnt_q  <= '0;
                            discard_q   <= 1'b0;
                            state_q     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        // Ack takes priority over a coincident timeout.
                        mem_req_q <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= IDLE;
                        if (!mem_ack) begin
                            timeout_q <= 1'b1;
                        end
                        if (!wb_suppress) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= (mem_ack && !mem_we_q) ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (flush) begin
                            discard_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign stall        = (state_q == WAIT);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_ReadData  = wb_data_q;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard testbench for mem_access_ctrl
// Stimulus pushes expected writebacks; a negedge monitor pops and compares on every wb_valid.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_ReadData;
    logic        misalign_err;
    logic        timeout_err;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.S(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_ReadData(wb_ReadData),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic mis);
        wb_exp_t e;
        e.data = data;
        e.mis  = mis;
        exp_q.push_back(e);
    endtask

    // Monitor: every wb_valid must match the oldest expected writeback.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb_valid", {31'd0, wb_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_ReadData", wb_ReadData, e.data);
                    chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
                end
            end else if (misalign_err) begin
                chk("misalign_without_wb", {31'd0, misalign_err}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; presents the op for one accept edge, then returns at the next negedge.
    task automatic present(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic fl);
        ex_valid    = 1'b1;
        ex_memread  = rd;
        ex_memwrite = wr;
        ex_addr     = addr;
        ex_wdata    = wd;
        flush       = fl;
        @(negedge clk);
        ex_valid    = 1'b0;
        ex_memread  = 1'b0;
        ex_memwrite = 1'b0;
        ex_addr     = 32'hFFFF_FFFF;
        ex_wdata    = 32'hFFFF_FFFF;
        flush       = 1'b0;
    endtask

    // Aligned access; ack asserted in WAIT cycle w (w=0: never ack), flush pulsed in WAIT cycle fl_at.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int w, input logic [31:0] rdv, input int fl_at,
                          input int exp_stall, input logic [31:0] exp_data);
        int  n;
        logic hold_ok;
        if (fl_at == 0) push_exp(exp_data, 1'b0);
        present(rd, wr, addr, wd, 1'b0);
        chk({name, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({name, "_mem_addr"}, mem_addr, addr);
        chk({name, "_mem_we"}, {31'd0, mem_we}, {31'd0, wr & ~rd});
        if (wr & ~rd) chk({name, "_mem_wdata"}, mem_wdata, wd);
        n = 0;
        hold_ok = 1'b1;
        while (stall && n < 64) begin
            n++;
            hold_ok &= (mem_req === 1'b1) && (mem_addr === addr) && (mem_wdata === wd);
            flush = (n == fl_at);
            if (n == w) begin
                mem_ack   = 1'b1;
                mem_rdata = rdv;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h5A5A_0F0F;
            flush     = 1'b0;
        end
        chk({name, "_stall_cycles"}, n, exp_stall);
        chk({name, "_req_held"}, {31'd0, hold_ok}, 32'd1);
        chk({name, "_req_dropped"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        ex_valid    = 1'b0;
        ex_memread  = 1'b0;
        ex_memwrite = 1'b0;
        ex_addr     = '0;
        ex_wdata    = '0;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_wb_ReadData", wb_ReadData, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Load, ack in third WAIT cycle
        access("load3", 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF);
        // Store, ack on first WAIT edge; returns 0
        access("store1", 1'b0, 1'b1, 32'h20, 32'h12345678, 1, 32'hCCCC_CCCC, 0, 1, 32'h0);
        // Read+write together behaves as a load
        access("rdwr", 1'b1, 1'b1, 32'h24, 32'h1111_2222, 2, 32'h0BAD_F00D, 0, 2, 32'h0BAD_F00D);

        // Misaligned load: no request, misalign pulse with zero data
        push_exp(32'h0, 1'b1);
        present(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        chk("misalign_no_req", {31'd0, mem_req}, 32'd0);
        chk("misalign_no_stall", {31'd0, stall}, 32'd0);

        // Non-memory op: zero writeback
        push_exp(32'h0, 1'b0);
        present(1'b0, 1'b0, 32'h44, 32'h0, 1'b0);
        chk("nonmem_no_req", {31'd0, mem_req}, 32'd0);

        // Flush at accept: consumed silently
        present(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        chk("flush_idle_no_req", {31'd0, mem_req}, 32'd0);
        chk("flush_idle_no_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);

        // Back-to-back loads, one access per two cycles
        access("b2b_a", 1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hA0A0_0001, 0, 1, 32'hA0A0_0001);
        access("b2b_b", 1'b1, 1'b0, 32'h104, 32'h0, 1, 32'hB0B0_0002, 0, 1, 32'hB0B0_0002);

        // Timeout: 16 WAIT cycles, sticky error, zero writeback
        chk("pre_timeout_err", {31'd0, timeout_err}, 32'd0);
        access("timeout", 1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0, 0, 16, 32'h0);
        chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_no_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_no_stall", {31'd0, stall}, 32'd0);

        // Flush during WAIT suppresses writeback; next op proceeds normally
        access("flush_wait", 1'b1, 1'b0, 32'h50, 32'h0, 3, 32'hAAAA5555, 1, 3, 32'h0);
        chk("flush_wb_hold", wb_ReadData, 32'h0);
        access("after_flush", 1'b1, 1'b0, 32'h54, 32'h0, 2, 32'hCAFEF00D, 0, 2, 32'hCAFEF00D);
        chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("wb_hold_value", wb_ReadData, 32'hCAFEF00D);

        // Asynchronous reset in the middle of WAIT
        present(1'b1, 1'b0, 32'h60, 32'h0, 1'b0);
        chk("pre_reset_stall", {31'd0, stall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        chk("async_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("async_rst_wb_ReadData", wb_ReadData, 32'd0);
        chk("async_rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_no_req", {31'd0, mem_req}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter S, default 32, datapath and address width in bits.
REQ-002 Parameter TIMEOUT, default 16, maximum number of WAIT cycles before abort; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 ex_valid  input  1  the EX/MEM operation presented this cycle is valid.
REQ-006 ex_memread  input  1  the operation is a load.
REQ-007 ex_memwrite  input  1  the operation is a store; when both this and ex_memread are 1, the operation is treated as a load.
REQ-008 ex_addr  input  S  byte address of the operation.
REQ-009 ex_wdata  input  S  store data.
REQ-010 flush  input  1  discard the current or pending operation's writeback.
REQ-011 mem_req  output  1  data-memory request strobe.
REQ-012 mem_we  output  1  1 = write, 0 = read.
REQ-013 mem_addr  output  S  latched request address.
REQ-014 mem_wdata  output  S  latched store data.
REQ-015 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-016 mem_rdata  input  S  read data, valid in the cycle in which mem_ack=1.
REQ-017 stall  output  1  hold upstream pipeline stages.
REQ-018 wb_valid  output  1  one-cycle pulse qualifying wb_ReadData toward the MEM/WB register.
REQ-019 wb_ReadData  output  S  load result; 0 for stores, non-memory operations and aborted operations.
REQ-020 misalign_err  output  1  one-cycle pulse for a misaligned access.
REQ-021 timeout_err  output  1  sticky flag set on timeout; cleared only by reset.

Function
REQ-022 The controller SHALL implement exactly two states: IDLE and WAIT.
REQ-023 stall SHALL be combinational and equal 1 if and only if state = WAIT.
REQ-024 In IDLE, ex_valid=1 with flush=0 SHALL be consumed at the rising edge.
REQ-025 In WAIT, all ex_* inputs SHALL be ignored; upstream holds the next operation until stall=0.
REQ-026 In IDLE, ex_valid=1 with flush=1 SHALL consume the operation with no memory request, no wb_valid pulse and no error pulse.
REQ-027 Consumed, aligned memory operation (ex_addr[1:0]=0): at the edge, latch ex_addr, ex_wdata and the write flag into mem_addr, mem_wdata and mem_we; set mem_req=1; enter WAIT.
REQ-028 Consumed, misaligned memory operation: no request is issued; in the next cycle misalign_err=1, wb_valid=1 and wb_ReadData=0; state stays IDLE.
REQ-029 Consumed non-memory operation: in the next cycle wb_valid=1 and wb_ReadData=0; state stays IDLE.
REQ-030 While in WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable until completion.
REQ-031 Completion is mem_ack=1 sampled at an edge while in WAIT, with the following results:
- mem_req drops in the next cycle;
- wb_valid pulses for one cycle;
- wb_ReadData = mem_rdata for a load, 0 for a store;
- state returns to IDLE.
REQ-032 Minimum latency: accept at edge N, ack sampled at edge N+1, wb_valid high in the cycle after edge N+1.
REQ-033 An 8-bit wait counter SHALL clear on entry to WAIT and increment on each WAIT edge without ack.
REQ-034 When the wait counter reaches TIMEOUT-1 without ack, at the next edge: set timeout_err; drop mem_req; pulse wb_valid with wb_ReadData=0; return to IDLE.
REQ-035 If ack and the timeout condition occur at the same edge, ack SHALL win and be handled as a normal completion.
REQ-036 mem_ack received while mem_req=0 SHALL be ignored.
REQ-037 flush=1 on any cycle while in WAIT SHALL set a discard flag; the transaction still runs to completion or timeout, but its wb_valid pulse is suppressed.
REQ-038 The discard flag SHALL clear on return to IDLE.
REQ-039 wb_ReadData SHALL hold its last value when wb_valid=0.
REQ-040 Back-to-back operation: a new operation may be accepted on the first IDLE cycle after completion, giving a throughput of at most one access per 2 cycles.

Reset
REQ-041 On reset=1, the following SHALL take effect asynchronously:
- state = IDLE;
- mem_req, mem_we, wb_valid, misalign_err and timeout_err = 0;
- mem_addr, mem_wdata, wb_ReadData, the wait counter and the discard flag = 0.
REQ-042 Reset asserted during WAIT SHALL drop mem_req immediately and produce no wb_valid pulse for the aborted operation.

Verification
REQ-043 Load, addr=0x10, ack after 3 WAIT cycles with rdata=0xDEADBEEF -> stall high for 3 cycles, then wb_valid=1 for 1 cycle with wb_ReadData=0xDEADBEEF.
REQ-044 Store, addr=0x20, wdata=0x12345678, ack on the first WAIT edge -> mem_we=1, mem_wdata=0x12345678 held; wb_valid pulse with wb_ReadData=0.
REQ-045 Load, addr=0x13 -> no mem_req; misalign_err and wb_valid each pulse 1 cycle; wb_ReadData=0.
REQ-046 Load with no ack, TIMEOUT=16 -> stall high for 16 cycles, then timeout_err=1 (sticky); wb_valid pulse with wb_ReadData=0; a later ack is ignored.
REQ-047 flush during WAIT, then ack with rdata=0xAAAA5555 -> no wb_valid pulse; next operation is accepted normally.
REQ-048 Reset asserted mid-WAIT, asynchronous to clk -> mem_req=0 and stall=0 before the next edge; all outputs at reset values.
